// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        JWAIT
    } fetch_state_t;

    localparam logic [31:0] INST_BYTES = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/response bus between fetch (master) and memory (slave).
interface fetch_unit_if;

    logic        IMEM_REQ_VALID;
    logic        IMEM_REQ_READY;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_RESP_VALID;
    logic [31:0] IMEM_RESP_DATA;

    modport master (
        output IMEM_REQ_VALID,
        output IMEM_ADDR,
        input  IMEM_REQ_READY,
        input  IMEM_RESP_VALID,
        input  IMEM_RESP_DATA
    );

    modport slave (
        input  IMEM_REQ_VALID,
        input  IMEM_ADDR,
        output IMEM_REQ_READY,
        output IMEM_RESP_VALID,
        output IMEM_RESP_DATA
    );

endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: single-outstanding imem requests, one-word buffer to the decoder,
// halts on control transfers until execute redirects.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         RST,
    fetch_unit_if.master imem,
    input  logic         STALL,
    input  logic         CONDITIONAL_JUMP,
    input  logic         REDIRECT_VALID,
    input  logic [31:0]  REDIRECT_PC,
    output logic [31:0]  INSTRUCTION,
    output logic [31:0]  PC,
    output logic         DECODER_ENABLED
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  buf_instr_q, buf_instr_d;
    logic [31:0]  buf_pc_q, buf_pc_d;
    logic         buf_valid_q, buf_valid_d;
    logic         kill_q, kill_d;

    logic         dec_en;
    logic         req_hs;

    assign dec_en          = buf_valid_q & ~STALL & ~REDIRECT_VALID;
    assign req_hs          = (state_q == REQ) & imem.IMEM_REQ_READY;

    assign DECODER_ENABLED = dec_en;
    assign INSTRUCTION     = buf_instr_q;
    assign PC              = buf_pc_q;
    assign imem.IMEM_REQ_VALID = (state_q == REQ);
    assign imem.IMEM_ADDR      = fetch_pc_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            buf_valid_q <= 1'b0;
            kill_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_valid_q <= buf_valid_d;
            kill_q      <= kill_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_valid_d = buf_valid_q;
        kill_d      = kill_q;

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (req_hs) state_d = WAIT;
            end
            WAIT: begin
                if (imem.IMEM_RESP_VALID) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        buf_instr_d = imem.IMEM_RESP_DATA;
                        buf_pc_d    = fetch_pc_q;
                        buf_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (dec_en) begin
                    buf_valid_d = 1'b0;
                    if (CONDITIONAL_JUMP) begin
                        state_d = JWAIT;
                    end else begin
                        fetch_pc_d = fetch_pc_q + INST_BYTES;
                        state_d    = REQ;
                    end
                end
            end
            JWAIT: ;
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything above; the buffer contents are left
        // untouched so a word arriving alongside the redirect is discarded.
        if (REDIRECT_VALID && state_q != IDLE) begin
            fetch_pc_d  = REDIRECT_PC & ~32'h3;
            buf_instr_d = buf_instr_q;
            buf_pc_d    = buf_pc_q;
            buf_valid_d = 1'b0;
            case (state_q)
                REQ: begin
                    state_d = req_hs ? WAIT : REQ;
                    kill_d  = req_hs ? 1'b1 : kill_q;
                end
                WAIT: begin
                    state_d = imem.IMEM_RESP_VALID ? REQ : WAIT;
                    kill_d  = ~imem.IMEM_RESP_VALID;
                end
                default: state_d = REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven check of fetch_unit plus a hand sequence for PC wrap and mid-HOLD reset.
module tb_fetch_unit;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    fetch_unit_if m0 ();
    fetch_unit_if m1 ();

    logic        stall0, cj0, xv0;
    logic [31:0] xpc0;
    logic [31:0] instr0, pc0;
    logic        de0;

    logic        stall1, cj1, xv1;
    logic [31:0] xpc1;
    logic [31:0] instr1, pc1;
    logic        de1;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .imem             (m0.master),
        .STALL            (stall0),
        .CONDITIONAL_JUMP (cj0),
        .REDIRECT_VALID   (xv0),
        .REDIRECT_PC      (xpc0),
        .INSTRUCTION      (instr0),
        .PC               (pc0),
        .DECODER_ENABLED  (de0)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .CLK              (CLK),
        .RST              (RST),
        .imem             (m1.master),
        .STALL            (stall1),
        .CONDITIONAL_JUMP (cj1),
        .REDIRECT_VALID   (xv1),
        .REDIRECT_PC      (xpc1),
        .INSTRUCTION      (instr1),
        .PC               (pc1),
        .DECODER_ENABLED  (de1)
    );

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        st;
        logic        cj;
        logic        xv;
        logic [31:0] xpc;
        logic        e_rq;
        logic [31:0] e_addr;
        logic        e_de;
        logic        e_cb;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [31:0] JAL = 32'h0300_006F;

    // addi x1, x0, addr[11:0] -- distinct non-jump word per address
    function automatic logic [31:0] W(input logic [31:0] a);
        return {a[11:0], 20'h00093};
    endfunction

    function automatic vec_t V(
        input logic rdy, input logic rv, input logic [31:0] rd, input logic st,
        input logic cj, input logic xv, input logic [31:0] xpc,
        input logic rq, input logic [31:0] addr, input logic de,
        input logic cb, input logic [31:0] pc, input logic [31:0] ins);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.st = st; v.cj = cj; v.xv = xv; v.xpc = xpc;
        v.e_rq = rq; v.e_addr = addr; v.e_de = de; v.e_cb = cb; v.e_pc = pc; v.e_ins = ins;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // cycle-by-cycle vectors, cycle 1 = first cycle after RST falls
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'h0,0,1,0,0));                 // 1 IDLE, reset state
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'h0,0,0,0,0));                 // 2 REQ 0
        tbl.push_back(V(1,1,W(0),0,0,0,0,     0,32'h0,0,0,0,0));                 // 3 WAIT resp
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'h0,1,1,32'h0,W(0)));          // 4 emit PC 0
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'h4,0,0,0,0));
        tbl.push_back(V(1,1,W(4),0,0,0,0,     0,32'h4,0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'h4,1,1,32'h4,W(4)));          // 7 emit PC 4
        tbl.push_back(V(0,0,0,0,0,0,0,        1,32'h8,0,0,0,0));                 // 8 backpressure
        tbl.push_back(V(0,0,0,0,0,0,0,        1,32'h8,0,0,0,0));
        tbl.push_back(V(0,0,0,0,0,0,0,        1,32'h8,0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'h8,0,0,0,0));
        tbl.push_back(V(1,1,W(8),0,0,0,0,     0,32'h8,0,0,0,0));
        tbl.push_back(V(1,0,0,1,0,0,0,        0,32'h8,0,1,32'h8,W(8)));          // 13 stalled
        tbl.push_back(V(1,0,0,1,0,0,0,        0,32'h8,0,1,32'h8,W(8)));
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'h8,1,1,32'h8,W(8)));          // 15 emit PC 8
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'hC,0,0,0,0));
        tbl.push_back(V(1,1,W(32'hC),0,0,0,0, 0,32'hC,0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'hC,1,1,32'hC,W(32'hC)));
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'h10,0,0,0,0));
        tbl.push_back(V(1,1,JAL,0,0,0,0,      0,32'h10,0,0,0,0));
        tbl.push_back(V(1,0,0,0,1,0,0,        0,32'h10,1,1,32'h10,JAL));         // 21 jal emitted
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'h10,0,0,0,0));                // JWAIT
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'h10,0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,1,32'h40,   0,32'h10,0,0,0,0));                // 24 redirect
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'h40,0,0,0,0));
        tbl.push_back(V(1,1,W(32'h40),0,0,0,0,0,32'h40,0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'h40,1,1,32'h40,W(32'h40)));
        tbl.push_back(V(0,0,0,0,0,1,32'h20,   1,32'h44,0,0,0,0));                // 28 redirect in REQ, no hs
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'h20,0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,1,32'h100,  0,32'h20,0,0,0,0));                // 30 redirect in WAIT
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'h100,0,0,0,0));
        tbl.push_back(V(1,1,W(32'h20),0,0,0,0,0,32'h100,0,0,0,0));               // 32 stale resp
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'h100,0,1,32'h40,W(32'h40)));
        tbl.push_back(V(1,1,W(32'h100),0,0,0,0,0,32'h100,0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'h100,1,1,32'h100,W(32'h100)));
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'h104,0,0,0,0));
        tbl.push_back(V(1,1,W(32'h104),0,0,1,32'h203, 0,32'h104,0,1,32'h100,W(32'h100))); // 37 resp + redirect
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'h200,0,1,32'h100,W(32'h100)));
        tbl.push_back(V(1,1,W(32'h200),0,0,0,0,0,32'h200,0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'h200,1,1,32'h200,W(32'h200)));
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'h204,0,0,0,0));
        tbl.push_back(V(1,1,W(32'h204),0,0,0,0,0,32'h204,0,0,0,0));
        tbl.push_back(V(1,0,0,1,0,0,0,        0,32'h204,0,1,32'h204,W(32'h204)));
        tbl.push_back(V(1,0,0,1,0,1,32'h300,  0,32'h204,0,1,32'h204,W(32'h204))); // 44 redirect under stall
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'h300,0,0,0,0));
        tbl.push_back(V(1,1,W(32'h300),0,0,0,0,0,32'h300,0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'h300,1,1,32'h300,W(32'h300)));
        tbl.push_back(V(1,0,0,0,0,1,32'h80,   1,32'h304,0,0,0,0));               // 48 redirect with hs
        tbl.push_back(V(1,1,W(32'h304),0,0,0,0,0,32'h80,0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,0,        1,32'h80,0,1,32'h300,W(32'h300)));
        tbl.push_back(V(1,1,W(32'h80),0,0,0,0,0,32'h80,0,0,0,0));
        tbl.push_back(V(1,0,0,0,0,0,0,        0,32'h80,1,1,32'h80,W(32'h80)));

        RST = 1'b1;
        stall0 = 0; cj0 = 0; xv0 = 0; xpc0 = '0;
        m0.IMEM_REQ_READY = 0; m0.IMEM_RESP_VALID = 0; m0.IMEM_RESP_DATA = '0;
        stall1 = 0; cj1 = 0; xv1 = 0; xpc1 = '0;
        m1.IMEM_REQ_READY = 0; m1.IMEM_RESP_VALID = 0; m1.IMEM_RESP_DATA = '0;
        step();
        step();
        RST = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            m0.IMEM_REQ_READY  = tbl[i].rdy;
            m0.IMEM_RESP_VALID = tbl[i].rv;
            m0.IMEM_RESP_DATA  = tbl[i].rd;
            stall0 = tbl[i].st;
            cj0    = tbl[i].cj;
            xv0    = tbl[i].xv;
            xpc0   = tbl[i].xpc;
            #1;
            chk("req_valid", i + 1, {31'b0, m0.IMEM_REQ_VALID}, {31'b0, tbl[i].e_rq});
            chk("imem_addr", i + 1, m0.IMEM_ADDR, tbl[i].e_addr);
            chk("dec_en",    i + 1, {31'b0, de0}, {31'b0, tbl[i].e_de});
            if (tbl[i].e_cb) begin
                chk("pc",    i + 1, pc0, tbl[i].e_pc);
                chk("instr", i + 1, instr0, tbl[i].e_ins);
            end
            step();
        end
        m0.IMEM_REQ_READY = 0; m0.IMEM_RESP_VALID = 0;
        stall0 = 0; cj0 = 0; xv0 = 0;

        // PC wrap from FFFF_FFFC and reset asserted while holding a word
        RST = 1'b1;
        step();
        RST = 1'b0;
        m1.IMEM_REQ_READY = 1;
        #1;
        chk("wrap_idle_rq", 101, {31'b0, m1.IMEM_REQ_VALID}, 32'd0);
        chk("wrap_idle_de", 101, {31'b0, de1}, 32'd0);
        step();
        chk("wrap_rq1",   102, {31'b0, m1.IMEM_REQ_VALID}, 32'd1);
        chk("wrap_addr1", 102, m1.IMEM_ADDR, 32'hFFFF_FFFC);
        step();
        m1.IMEM_RESP_VALID = 1; m1.IMEM_RESP_DATA = W(32'hFFFF_FFFC);
        step();
        m1.IMEM_RESP_VALID = 0; m1.IMEM_RESP_DATA = '0;
        #1;
        chk("wrap_de1", 104, {31'b0, de1}, 32'd1);
        chk("wrap_pc1", 104, pc1, 32'hFFFF_FFFC);
        step();
        chk("wrap_rq2",   105, {31'b0, m1.IMEM_REQ_VALID}, 32'd1);
        chk("wrap_addr2", 105, m1.IMEM_ADDR, 32'h0);
        step();
        m1.IMEM_RESP_VALID = 1; m1.IMEM_RESP_DATA = W(32'h0);
        step();
        m1.IMEM_RESP_VALID = 0; m1.IMEM_RESP_DATA = '0;
        stall1 = 1;
        RST = 1'b1;
        #1;
        chk("hold_de",    107, {31'b0, de1}, 32'd0);
        chk("hold_pc",    107, pc1, 32'h0);
        chk("hold_instr", 107, instr1, W(32'h0));
        step();
        RST = 1'b0;
        stall1 = 0;
        #1;
        chk("rst_de",    108, {31'b0, de1}, 32'd0);
        chk("rst_rq",    108, {31'b0, m1.IMEM_REQ_VALID}, 32'd0);
        chk("rst_instr", 108, instr1, 32'h0);
        chk("rst_addr",  108, m1.IMEM_ADDR, 32'hFFFF_FFFC);
        step();
        chk("restart_rq",   109, {31'b0, m1.IMEM_REQ_VALID}, 32'd1);
        chk("restart_addr", 109, m1.IMEM_ADDR, 32'hFFFF_FFFC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
